// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
//   Receive side of a TDM link. Slot 0 of each frame is marked by in_sync.
//   Beats are collected slot by slot into shadow registers. When the final slot
//   arrives, the complete frame is published on out_data in parallel.
//
// Parameters
//   WIDTH : bits per beat/slot
//   SLOTS : slots per frame (>= 2)
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous reset, active low
//   in_valid  : beat present on in_data
//   in_sync   : qualifies in_valid, marks the beat as slot 0
//   in_data   : beat payload
//   out_data  : last complete frame, slot k at [k*WIDTH +: WIDTH]
//   out_valid : 1-cycle pulse when out_data was updated
//   locked    : 1 while in RUN
//   slot_idx  : slot number the next accepted beat fills
//   sync_err  : 1-cycle framing-error pulse
//
// Build option
//   TDM_SYNC_CHECK_EN : when defined, the block checks in_sync while in RUN and
//                       resynchronises or drops lock on framing errors. When it
//                       is undefined, the block free-runs on the slot count and
//                       sync_err is tied low.
// -----------------------------------------------------------------------------
module tdm_demux #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLOTS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_sync,
    input  logic [WIDTH-1:0]           in_data,
    output logic [WIDTH*SLOTS-1:0]     out_data,
    output logic                       out_valid,
    output logic                       locked,
    output logic [$clog2(SLOTS)-1:0]   slot_idx,
    output logic                       sync_err
);

    localparam int unsigned SW        = $clog2(SLOTS);
    localparam int unsigned FW        = WIDTH * SLOTS;
    localparam int unsigned SHW       = WIDTH * (SLOTS - 1);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_slot;
    logic [SHW-1:0]  r_shadow;
    logic [FW-1:0]   r_out_data;
    logic            r_out_valid;

    state_t          w_nxt_state;
    logic [SW-1:0]   w_nxt_slot;
    logic            w_wr_en;
    logic [SW-1:0]   w_wr_idx;
    logic            w_frame_done;
`ifdef TDM_SYNC_CHECK_EN
    logic            w_err;
    logic            r_sync_err;
`endif

    // Next-state, slot sequencing and framing decisions
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_slot   = r_slot;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_slot;
        w_frame_done = 1'b0;
`ifdef TDM_SYNC_CHECK_EN
        w_err        = 1'b0;
`endif
        case (r_state)
            ST_HUNT: begin
                if (in_valid && in_sync) begin
                    w_wr_en     = 1'b1;
                    w_wr_idx    = '0;
                    w_nxt_slot  = SW'(1);
                    w_nxt_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
`ifdef TDM_SYNC_CHECK_EN
                    if (in_sync && (r_slot != '0)) begin
                        // Early sync: abandon the partial frame, restart at slot 0
                        w_err      = 1'b1;
                        w_wr_en    = 1'b1;
                        w_wr_idx   = '0;
                        w_nxt_slot = SW'(1);
                    end else if (!in_sync && (r_slot == '0)) begin
                        // Missing sync at frame start: drop beat and lose lock
                        w_err       = 1'b1;
                        w_nxt_slot  = '0;
                        w_nxt_state = ST_HUNT;
                    end else
`endif
                    if (r_slot == LAST_SLOT) begin
                        w_frame_done = 1'b1;
                        w_nxt_slot   = '0;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_nxt_slot = r_slot + SW'(1);
                    end
                end
            end
            default: begin
                w_nxt_state = ST_HUNT;
                w_nxt_slot  = '0;
            end
        endcase
    end

    // State and slot counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
            r_slot  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_slot  <= w_nxt_slot;
        end
    end

    // Shadow capture for slots 0..SLOTS-2; the last slot goes straight out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else begin
            for (int k = 0; k < int'(SLOTS) - 1; k++) begin
                if (w_wr_en && (w_wr_idx == SW'(k))) begin
                    r_shadow[k*WIDTH +: WIDTH] <= in_data;
                end
            end
        end
    end

    // Frame publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_frame_done;
            if (w_frame_done) begin
                r_out_data <= {in_data, r_shadow};
            end
        end
    end

`ifdef TDM_SYNC_CHECK_EN
    // Framing-error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_err;
        end
    end
    assign sync_err = r_sync_err;
`else
    assign sync_err = 1'b0;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign locked    = (r_state == ST_RUN);
    assign slot_idx  = r_slot;

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
//   Directed bench for tdm_demux (WIDTH=8, SLOTS=4). A frame-level model built
//   on a queue of captured beats predicts every output; a compare process
//   checks the DUT against it on each falling edge. Literal expectations pin
//   the model on the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_tdm_demux;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SLOTS = 4;
    localparam int unsigned FW    = WIDTH * SLOTS;
    localparam int unsigned SW    = $clog2(SLOTS);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_sync;
    logic [WIDTH-1:0]  in_data;
    logic [FW-1:0]     out_data;
    logic              out_valid;
    logic              locked;
    logic [SW-1:0]     slot_idx;
    logic              sync_err;

    int n_tests;
    int n_fail;
    int n_valid_pulses;
    int n_err_pulses;

    tdm_demux #(.WIDTH(WIDTH), .SLOTS(SLOTS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .locked    (locked),
        .slot_idx  (slot_idx),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    logic [WIDTH-1:0] m_q[$];
    bit               m_locked;
    logic [FW-1:0]    m_out;
    bit               m_ov;
    bit               m_err;
    bit               m_check_sync;

    initial begin
`ifdef TDM_SYNC_CHECK_EN
        m_check_sync = 1'b1;
`else
        m_check_sync = 1'b0;
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_locked = 1'b0;
            m_out    = '0;
            m_ov     = 1'b0;
            m_err    = 1'b0;
        end else begin
            m_ov  = 1'b0;
            m_err = 1'b0;
            if (in_valid) begin
                if (!m_locked) begin
                    if (in_sync) begin
                        m_q.delete();
                        m_q.push_back(in_data);
                        m_locked = 1'b1;
                    end
                end else if (m_check_sync && in_sync && m_q.size() != 0) begin
                    m_err = 1'b1;
                    m_q.delete();
                    m_q.push_back(in_data);
                end else if (m_check_sync && !in_sync && m_q.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_q.push_back(in_data);
                    if (m_q.size() == SLOTS) begin
                        for (int k = 0; k < int'(SLOTS); k++)
                            m_out[k*WIDTH +: WIDTH] = m_q[k];
                        m_ov = 1'b1;
                        m_q.delete();
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("out_data",  64'(out_data),  64'(m_out));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("locked",    64'(locked),    64'(m_locked));
        check("slot_idx",  64'(slot_idx),  64'(m_locked ? m_q.size() : 0));
        check("sync_err",  64'(sync_err),  64'(m_err));
        if (out_valid) n_valid_pulses++;
        if (sync_err)  n_err_pulses++;
    end

    // ---------------- stimulus ----------------
    task automatic beat(input bit v, input bit s, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        n_tests = 0;
        n_fail = 0;
        n_valid_pulses = 0;
        n_err_pulses = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sync = 1'b0;
        in_data = '0;
        repeat (3) @(negedge clk);
        check("reset_out_data", 64'(out_data), 64'h0);
        check("reset_locked",   64'(locked),   64'h0);
        rst_n = 1'b1;
        idle(2);

        // Pre-lock garbage, then a frame
        beat(1, 0, 8'hAA);
        beat(1, 0, 8'hBB);
        check("hunt_locked", 64'(locked), 64'h0);
        check("hunt_slot",   64'(slot_idx), 64'h0);
        beat(1, 1, 8'h01);
        check("lock_rise", 64'(locked), 64'h1);
        beat(1, 0, 8'h02);
        beat(1, 0, 8'h03);
        beat(1, 0, 8'h04);
        check("garbage_frame", 64'(out_data), 64'h04030201);
        idle(2);

        // Basic frame
        base = n_valid_pulses;
        beat(1, 1, 8'h11);
        beat(1, 0, 8'h22);
        beat(1, 0, 8'h33);
        check("basic_no_early_valid", 64'(out_valid), 64'h0);
        beat(1, 0, 8'h44);
        check("basic_valid", 64'(out_valid), 64'h1);
        check("basic_data",  64'(out_data),  64'h44332211);
        check("basic_locked", 64'(locked),   64'h1);
        idle(3);
        check("basic_hold", 64'(out_data), 64'h44332211);

        // Gaps between beats
        base = n_valid_pulses;
        beat(1, 1, 8'h11); idle(3);
        check("gap_slot_hold", 64'(slot_idx), 64'h1);
        beat(1, 0, 8'h22); idle(3);
        beat(1, 0, 8'h33); idle(3);
        check("gap_slot_hold3", 64'(slot_idx), 64'h3);
        beat(1, 0, 8'h44); idle(3);
        check("gap_pulses", 64'(n_valid_pulses - base), 64'h1);
        check("gap_data",   64'(out_data), 64'h44332211);

        // Back-to-back frames
        base = n_valid_pulses;
        beat(1, 1, 8'h11); beat(1, 0, 8'h22); beat(1, 0, 8'h33); beat(1, 0, 8'h44);
        check("b2b_first", 64'(out_data), 64'h44332211);
        beat(1, 1, 8'h55); beat(1, 0, 8'h66); beat(1, 0, 8'h77);
        check("b2b_mid_valid", 64'(out_valid), 64'h0);
        beat(1, 0, 8'h88);
        check("b2b_second_valid", 64'(out_valid), 64'h1);
        idle(1);
        check("b2b_pulses", 64'(n_valid_pulses - base), 64'h2);
        check("b2b_data",   64'(out_data), 64'h88776655);
        idle(2);

        // Early sync
        base = n_err_pulses;
        beat(1, 1, 8'h11); beat(1, 0, 8'h22);
        beat(1, 1, 8'h55); beat(1, 0, 8'h66); beat(1, 0, 8'h77); beat(1, 0, 8'h88);
        idle(2);
`ifdef TDM_SYNC_CHECK_EN
        check("early_sync_err", 64'(n_err_pulses - base), 64'h1);
        check("early_sync_data", 64'(out_data), 64'h88776655);
`else
        check("early_sync_err", 64'(n_err_pulses - base), 64'h0);
        check("early_sync_data", 64'(out_data), 64'h66552211);
`endif

        // Reset mid-frame: asserted between edges, outputs clear at once
        beat(1, 1, 8'h01); beat(1, 0, 8'h02);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_data", 64'(out_data),  64'h0);
        check("rst_locked",   64'(locked),    64'h0);
        check("rst_slot",     64'(slot_idx),  64'h0);
        check("rst_valid",    64'(out_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        beat(1, 1, 8'h01); beat(1, 0, 8'h02); beat(1, 0, 8'h03); beat(1, 0, 8'h04);
        check("post_rst_data", 64'(out_data), 64'h04030201);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
